// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path: the receiver FSM state
// encoding and the oversampling / frame geometry constants.
// -----------------------------------------------------------------------------
package uart_pkg;

    // Receiver frame-tracking states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    localparam int OVS         = 16; // baud ticks per bit
    localparam int MID_START   = 7;  // s_cnt value at the middle of the start bit
    localparam int LAST_SAMPLE = 15; // s_cnt value at the middle of data/stop bits
    localparam int DATA_BITS   = 8;  // payload bits per frame

endpackage : uart_pkg

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Free-running divider producing one oversampling tick every DIV clocks.
// Ports:
//   rxclk   in  : system clock, rising edge
//   reset   in  : asynchronous active-low reset
//   restart in  : reload the divider to 0 (aligns ticks to a start edge)
//   tick    out : high for one clock when the divider wraps
// -----------------------------------------------------------------------------
module uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic rxclk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        tick  = (cnt_q == CW'(DIV - 1));
        cnt_d = tick ? '0 : cnt_q + CW'(1);
        if (restart) begin
            cnt_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together on the edge, independent of statement order.
    always_ff @(posedge rxclk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : uart_baud_tick

// File: rtl/uart_rx_core.sv
// -----------------------------------------------------------------------------
// uart_rx_core
// 8N1 UART receiver with 16x oversampling derived from the system clock.
// Ports:
//   rxclk        in     : system clock, rising edge
//   reset        in     : asynchronous active-low reset
//   rx_enable    in     : receiver enable; low aborts a frame in progress
//   rx_in        in     : asynchronous serial line, idle high
//   uld_rx_data  in     : one-cycle strobe marking rx_data as consumed
//   rx_data      out[8] : last received byte, LSB received first
//   rx_empty     out    : no unread byte held
//   rx_frame_err out    : stop bit of the held byte was low
//   rx_overrun   out    : a byte arrived while the previous one was unread
//   rx_busy      out    : receiver is inside a frame (not IDLE)
// -----------------------------------------------------------------------------
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int clk_freq = 50000000,
    parameter int baud     = 115200
) (
    input  logic       rxclk,
    input  logic       reset,
    input  logic       rx_enable,
    input  logic       rx_in,
    input  logic       uld_rx_data,
    output logic [7:0] rx_data,
    output logic       rx_empty,
    output logic       rx_frame_err,
    output logic       rx_overrun,
    output logic       rx_busy
);

    // Clocks per oversampling tick; must come out >= 1.
    localparam int DIV = clk_freq / (baud * OVS);

    rx_state_e  state_q, state_d;
    logic [1:0] sync_q;
    logic [3:0] s_cnt_q, s_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_q, data_d;
    logic       empty_q, empty_d;
    logic       ferr_q, ferr_d;
    logic       ovr_q, ovr_d;
    logic       busy_q, busy_d;
    logic       line;
    logic       tick;
    logic       restart;

    uart_baud_tick #(
        .DIV (DIV)
    ) u_baud_tick (
        .rxclk   (rxclk),
        .reset   (reset),
        .restart (restart),
        .tick    (tick)
    );

    // Two-flop synchronizer output; all sampling uses this value.
    assign line = sync_q[1];

    always_comb begin
        state_d   = state_q;
        s_cnt_d   = s_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        empty_d   = empty_q;
        ferr_d    = ferr_q;
        ovr_d     = ovr_q;
        restart   = 1'b0;

        // Unload is applied first so a frame completing in the same cycle
        // overrides it below.
        if (uld_rx_data) begin
            empty_d = 1'b1;
            ferr_d  = 1'b0;
            ovr_d   = 1'b0;
        end

        if (!rx_enable) begin
            // Abort: drop the partial frame, keep the held byte and flags.
            state_d   = IDLE;
            s_cnt_d   = '0;
            bit_cnt_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!line) begin
                        state_d = START;
                        s_cnt_d = '0;
                        restart = 1'b1; // align tick phase to the start edge
                    end
                end
                START: begin
                    if (tick) begin
                        if (s_cnt_q == 4'(MID_START)) begin
                            if (!line) begin
                                state_d   = DATA;
                                s_cnt_d   = '0;
                                bit_cnt_d = '0;
                            end else begin
                                state_d = IDLE; // glitch, not a real start bit
                            end
                        end else begin
                            s_cnt_d = s_cnt_q + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        s_cnt_d = s_cnt_q + 4'd1; // wraps 15 -> 0 for the next bit
                        if (s_cnt_q == 4'(LAST_SAMPLE)) begin
                            shift_d   = {line, shift_q[7:1]};
                            bit_cnt_d = bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
                                state_d = STOP;
                            end
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        s_cnt_d = s_cnt_q + 4'd1;
                        if (s_cnt_q == 4'(LAST_SAMPLE)) begin
                            data_d  = shift_q;
                            empty_d = 1'b0;
                            ferr_d  = !line;
                            // A byte unloaded on this very cycle is not overrun.
                            ovr_d   = !empty_q && !uld_rx_data;
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    // NOTE: every register, including the data holding register, is reset so
    // the outputs are defined from the first clock after reset.
    always_ff @(posedge rxclk or negedge reset) begin
        if (!reset) begin
            sync_q    <= 2'b11;
            state_q   <= IDLE;
            s_cnt_q   <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= 8'h00;
            empty_q   <= 1'b1;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], rx_in};
            state_q   <= state_d;
            s_cnt_q   <= s_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            empty_q   <= empty_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
            busy_q    <= busy_d;
        end
    end

    assign rx_data      = data_q;
    assign rx_empty     = empty_q;
    assign rx_frame_err = ferr_q;
    assign rx_overrun   = ovr_q;
    assign rx_busy      = busy_q;

endmodule : uart_rx_core

// File: tb/tb_uart_rx_core.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_core
// Scoreboard bench for uart_rx_core at DIV = 1 (16 clocks per bit). The
// stimulus pushes the expected byte/flags for each frame that must complete;
// a monitor pops and compares whenever the receiver finishes a full frame.
// -----------------------------------------------------------------------------
module tb_uart_rx_core;

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        logic       ovr;
    } exp_t;

    logic       rxclk;
    logic       reset;
    logic       rx_enable;
    logic       rx_in;
    logic       uld_rx_data;
    logic [7:0] rx_data;
    logic       rx_empty;
    logic       rx_frame_err;
    logic       rx_overrun;
    logic       rx_busy;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   lat_n;
    int   busy_len = 0;
    logic busy_prev = 1'b0;
    exp_t mon_e;

    uart_rx_core #(
        .clk_freq (1600000),
        .baud     (100000)
    ) dut (
        .rxclk        (rxclk),
        .reset        (reset),
        .rx_enable    (rx_enable),
        .rx_in        (rx_in),
        .uld_rx_data  (uld_rx_data),
        .rx_data      (rx_data),
        .rx_empty     (rx_empty),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun),
        .rx_busy      (rx_busy)
    );

    initial rxclk = 1'b0;
    always #5 rxclk = ~rxclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance n rising edges and settle just after the last one.
    task automatic wait_clk(input int n);
        repeat (n) @(posedge rxclk);
        #1;
    endtask

    task automatic unload();
        uld_rx_data = 1'b1;
        wait_clk(1);
        uld_rx_data = 1'b0;
    endtask

    // One 8N1 frame, 16 clocks per bit. With uld_at_end the unload strobe is
    // sampled on the same edge that completes the frame (155 clocks after
    // the start edge).
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input bit uld_at_end);
        rx_in = 1'b0;
        wait_clk(16);
        for (int i = 0; i < 8; i++) begin
            rx_in = d[i];
            wait_clk(16);
        end
        rx_in = stop_bit;
        if (uld_at_end) begin
            wait_clk(10);
            uld_rx_data = 1'b1;
            wait_clk(1);
            uld_rx_data = 1'b0;
            wait_clk(5);
        end else begin
            wait_clk(16);
        end
        rx_in = 1'b1;
    endtask

    // Monitor: a full frame ends when rx_busy falls after a long busy run
    // with a byte held. Short busy runs (glitches, aborts) are ignored.
    initial begin
        forever begin
            @(negedge rxclk);
            if (busy_prev && !rx_busy && busy_len >= 144 && !rx_empty) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", 32'(rx_data), 32'hFFFF_FFFF);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("sb_data", 32'(rx_data), 32'(mon_e.data));
                    check("sb_frame_err", 32'(rx_frame_err), 32'(mon_e.ferr));
                    check("sb_overrun", 32'(rx_overrun), 32'(mon_e.ovr));
                end
            end
            busy_len  = rx_busy ? busy_len + 1 : 0;
            busy_prev = rx_busy;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b0;
        rx_enable   = 1'b1;
        rx_in       = 1'b1;
        uld_rx_data = 1'b0;
        wait_clk(3);
        reset = 1'b1;
        wait_clk(2);

        // 1. Reset state with an idle line.
        check("rst_empty", 32'(rx_empty), 32'd1);
        check("rst_data", 32'(rx_data), 32'h00);
        check("rst_frame_err", 32'(rx_frame_err), 32'd0);
        check("rst_overrun", 32'(rx_overrun), 32'd0);
        check("rst_busy", 32'(rx_busy), 32'd0);

        // 2. A5 with latency measurement, then unload.
        exp_q.push_back('{data: 8'hA5, ferr: 1'b0, ovr: 1'b0});
        fork
            send_frame(8'hA5, 1'b1, 1'b0);
            begin
                lat_n = 0;
                while (rx_empty && lat_n < 400) begin
                    @(posedge rxclk);
                    #1;
                    lat_n++;
                end
                check("a5_latency", 32'(lat_n), 32'd155);
            end
        join
        wait_clk(4);
        unload();
        check("a5_unload_empty", 32'(rx_empty), 32'd1);
        check("a5_unload_data", 32'(rx_data), 32'hA5);

        // 3. Back-to-back 3C, C3 without unloading -> overrun.
        exp_q.push_back('{data: 8'h3C, ferr: 1'b0, ovr: 1'b0});
        send_frame(8'h3C, 1'b1, 1'b0);
        exp_q.push_back('{data: 8'hC3, ferr: 1'b0, ovr: 1'b1});
        send_frame(8'hC3, 1'b1, 1'b0);
        wait_clk(4);
        check("ovr_flag", 32'(rx_overrun), 32'd1);
        unload();
        check("ovr_cleared", 32'(rx_overrun), 32'd0);
        check("ovr_unload_empty", 32'(rx_empty), 32'd1);

        // 4. 55 with the stop bit low -> framing error, byte still delivered.
        exp_q.push_back('{data: 8'h55, ferr: 1'b1, ovr: 1'b0});
        send_frame(8'h55, 1'b0, 1'b0);
        wait_clk(40);
        check("ferr_empty", 32'(rx_empty), 32'd0);
        check("ferr_flag", 32'(rx_frame_err), 32'd1);
        check("ferr_data", 32'(rx_data), 32'h55);
        unload();
        check("ferr_cleared", 32'(rx_frame_err), 32'd0);

        // 5. 4-clock glitch on an idle line, then 01.
        rx_in = 1'b0;
        wait_clk(4);
        rx_in = 1'b1;
        wait_clk(30);
        check("glitch_empty", 32'(rx_empty), 32'd1);
        check("glitch_busy", 32'(rx_busy), 32'd0);
        exp_q.push_back('{data: 8'h01, ferr: 1'b0, ovr: 1'b0});
        send_frame(8'h01, 1'b1, 1'b0);
        wait_clk(4);
        unload();

        // 6. Abort FF mid-DATA via rx_enable, then 7E, then 81 with an unload
        //    strobe on the completion cycle while 7E is still unread.
        rx_in = 1'b0;
        wait_clk(16);
        rx_in = 1'b1;
        wait_clk(40);
        rx_enable = 1'b0;
        wait_clk(2);
        check("abort_busy", 32'(rx_busy), 32'd0);
        wait_clk(100);
        rx_enable = 1'b1;
        wait_clk(5);
        check("abort_empty", 32'(rx_empty), 32'd1);
        check("abort_data", 32'(rx_data), 32'h01);

        exp_q.push_back('{data: 8'h7E, ferr: 1'b0, ovr: 1'b0});
        send_frame(8'h7E, 1'b1, 1'b0);
        wait_clk(4);
        check("7e_data", 32'(rx_data), 32'h7E);
        exp_q.push_back('{data: 8'h81, ferr: 1'b0, ovr: 1'b0});
        send_frame(8'h81, 1'b1, 1'b1);
        wait_clk(4);
        check("uld_race_empty", 32'(rx_empty), 32'd0);
        check("uld_race_overrun", 32'(rx_overrun), 32'd0);

        // Every pushed expectation must have been consumed by the monitor.
        wait_clk(20);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_uart_rx_core
